imem_loader: RTL and testbench

- Writer side of the instruction memory: receives a program as a byte stream and issues word writes to the instruction store's write port.
- The CPU core is held idle while a load is in progress; `done` releases it.
- Word addresses are byte addresses, word-aligned (bits [1:0] = 0), so that bits [addr_data-1:2] index the instruction array exactly as the fetch path reads it.
- Typical source is a UART receiver or a testbench byte driver.

---
 rtl/imem_loader.sv | 179 +++++++++++++++++
 tb/tb_imem_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction memory. A program arrives as a byte stream:
// a 16-bit word count N (MSB first) followed by N 32-bit words (MSB first).
// Each assembled word is written to the instruction store as a one-cycle
// write strobe with a word-aligned byte address. The CPU core is held idle
// while busy is high. done releases it, and error flags a rejected length.
//
// Parameters
//   mem_size   number of 32-bit words in the instruction store (1..65535)
//   addr_data  width of the instruction word and of the write address
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse that begins a load (IDLE/DONE/ERR only)
//   byte_in     stream data byte
//   byte_valid  byte_in is valid this cycle
//   byte_ready  loader accepts a byte this cycle
//   we          write strobe to the instruction store, one cycle per word
//   waddr       byte address of the word being written (bits [1:0] = 0)
//   wdata       instruction word being written
//   busy        a load is in progress
//   done        last load completed successfully (held)
//   error       last load rejected because of a bad length (held)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int mem_size  = 256,
    parameter int addr_data = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 we,
    output logic [addr_data-1:0] waddr,
    output logic [addr_data-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_WORD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [15:0] MEM_WORDS = 16'(mem_size);

    state_e               state_q;
    logic [15:0]          len_q;
    logic [15:0]          word_idx_q;
    logic [1:0]           byte_cnt_q;
    logic [23:0]          shift_q;     // first three bytes of the word in flight
    logic                 byte_ready_q;
    logic                 we_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic [addr_data-1:0] waddr_q;
    logic [addr_data-1:0] wdata_q;

    logic                 accept;
    logic [15:0]          len_d;
    logic                 len_bad;
    logic [31:0]          word_d;
    logic [15:0]          word_idx_d;

    // byte_ready_q is the registered handshake, so the transfer condition
    // never depends combinationally on byte_valid.
    assign accept     = byte_valid && byte_ready_q;
    assign len_d      = {len_q[15:8], byte_in};
    assign len_bad    = (len_d == 16'd0) || (len_d > MEM_WORDS);
    assign word_d     = {shift_q, byte_in};
    assign word_idx_d = word_idx_q + 16'd1;

    // All outputs are registered and updated together with the state, so
    // they always reflect the state the machine is in this cycle.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the value from before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            we_q <= 1'b0;  // strobe is raised only on the way into S_WRITE
            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q      <= S_LEN_HI;
                        byte_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        word_idx_q   <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= byte_in;
                        state_q     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_q <= len_d;
                        if (len_bad) begin
                            state_q      <= S_ERR;
                            byte_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            error_q      <= 1'b1;
                        end else begin
                            state_q    <= S_WORD;
                            byte_cnt_q <= '0;
                        end
                    end
                end
                S_WORD: begin
                    if (accept) begin
                        shift_q    <= word_d[23:0];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // Fourth byte: present the write in the next cycle.
                            state_q      <= S_WRITE;
                            byte_ready_q <= 1'b0;
                            we_q         <= 1'b1;
                            waddr_q      <= addr_data'({word_idx_q, 2'b00});
                            wdata_q      <= addr_data'(word_d);
                        end
                    end
                end
                S_WRITE: begin
                    word_idx_q <= word_idx_d;
                    if (word_idx_d == len_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q      <= S_WORD;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    byte_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Drives byte streams (fixed scenarios plus randomized loads) into
// imem_loader. A byte-count model predicts every output each cycle, and a
// memory scoreboard compares the captured writes against the program that
// was sent.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int MEM = 256;
    localparam int AW  = 32;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic [7:0]    byte_in    = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          error;

    imem_loader #(.mem_size(MEM), .addr_data(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Progress through a load is tracked as the number of bytes consumed:
    // bytes 0..1 are the length, every later group of four is one word.
    logic          m_ready = 1'b0, m_we = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_error = 1'b0;
    logic [AW-1:0] m_waddr = '0, m_wdata = '0;
    logic [15:0]   m_len = '0, m_idx = '0;
    logic [31:0]   m_word = '0;
    int            m_nbytes = 0;
    logic [15:0]   m_full;

    assign m_full = {m_len[15:8], byte_in};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b0; m_we <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_error <= 1'b0;
            m_waddr <= '0; m_wdata <= '0; m_len <= '0; m_idx <= '0; m_word <= '0; m_nbytes <= 0;
        end else if (m_we) begin
            m_we  <= 1'b0;
            m_idx <= m_idx + 16'd1;
            if (m_idx + 16'd1 == m_len) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_ready <= 1'b1;
            end
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1; m_ready <= 1'b1; m_done <= 1'b0; m_error <= 1'b0;
                m_idx <= '0; m_nbytes <= 0;
            end
        end else if (byte_valid && m_ready) begin
            m_nbytes <= m_nbytes + 1;
            if (m_nbytes == 0) begin
                m_len <= {byte_in, 8'h00};
            end else if (m_nbytes == 1) begin
                m_len <= m_full;
                if (m_full == 16'd0 || int'(m_full) > MEM) begin
                    m_error <= 1'b1; m_busy <= 1'b0; m_ready <= 1'b0;
                end
            end else begin
                m_word <= {m_word[23:0], byte_in};
                if ((m_nbytes - 2) % 4 == 3) begin
                    m_we    <= 1'b1;
                    m_ready <= 1'b0;
                    m_waddr <= {14'd0, m_idx, 2'b00};
                    m_wdata <= {m_word[23:0], byte_in};
                end
            end
        end
    end

    // ---------------- per-cycle compare and write capture ----------------
    logic [31:0]   dut_mem [MEM];
    int            wr_count = 0;
    logic [AW-1:0] last_waddr = '0, last_wdata = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("cycle {rdy,we,busy,done,err,waddr,wdata}",
                  {59'd0, byte_ready, we, busy, done, error, waddr, wdata},
                  {59'd0, m_ready, m_we, m_busy, m_done, m_error, m_waddr, m_wdata});
            if (we) begin
                wr_count++;
                last_waddr = waddr;
                last_wdata = wdata;
                if (waddr[1:0] == 2'b00 && waddr < AW'(MEM * 4)) dut_mem[int'(waddr >> 2)] = wdata;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] words[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
        bit got;
        int waited;
        repeat (gap) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            start      = noise && ($urandom_range(15, 0) == 0);
            step();
        end
        byte_valid = 1'b1;
        byte_in    = b;
        got        = 1'b0;
        waited     = 0;
        while (!got && waited < 64) begin
            got   = byte_ready;  // registered, so this is the value seen at the next edge
            start = noise && ($urandom_range(15, 0) == 0);
            step();
            waited++;
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        check("byte handshake", {127'd0, got}, 128'd1);
    endtask

    task automatic run_load(input string tag, input logic [15:0] n_len, input int min_gap,
                            input int max_gap, input bit noise, input bit overlap);
        logic [7:0] stream[$];
        bit         good;
        int         waited;
        good = (n_len != 16'd0) && (int'(n_len) <= MEM);
        stream.push_back(n_len[15:8]);
        stream.push_back(n_len[7:0]);
        if (good)
            foreach (words[i])
                for (int k = 3; k >= 0; k--) stream.push_back(8'(words[i] >> (8 * k)));
        for (int i = 0; i < MEM; i++) dut_mem[i] = 'x;
        wr_count = 0;

        start      = 1'b1;
        byte_valid = overlap;
        byte_in    = stream[0];
        step();
        start      = 1'b0;
        byte_valid = 1'b0;
        foreach (stream[i]) send_byte(stream[i], $urandom_range(max_gap, min_gap), noise && good);

        waited = 0;
        while (!(done || error) && waited < 40) begin
            step();
            waited++;
        end
        check({tag, " completion"}, {127'd0, done || error}, 128'd1);
        if (good) begin
            check({tag, " {busy,done,err}"}, {125'd0, busy, done, error}, 128'b010);
            check({tag, " write count"}, 128'(wr_count), 128'(n_len));
            foreach (words[i]) check({tag, " mem word"}, {96'd0, dut_mem[i]}, {96'd0, words[i]});
        end else begin
            check({tag, " {busy,done,err,rdy}"}, {124'd0, busy, done, error, byte_ready}, 128'b0010);
            check({tag, " write count"}, 128'(wr_count), 128'd0);
        end
    endtask

    task automatic junk_bytes(input int n);
        repeat (n) begin
            byte_valid = 1'b1;
            byte_in    = 8'($urandom);
            step();
        end
        byte_valid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] n;
        repeat (3) step();
        check("reset outputs", {59'd0, byte_ready, we, busy, done, error, waddr, wdata}, 128'd0);
        rst_n = 1'b1;
        step();

        // Two-word load.
        words = '{32'h2008_0005, 32'hAC08_0000};
        run_load("two_word", 16'd2, 0, 0, 1'b0, 1'b0);
        check("two_word mem[0] literal", {96'd0, dut_mem[0]}, 128'h2008_0005);
        check("two_word mem[1] literal", {96'd0, dut_mem[1]}, 128'hAC08_0000);
        check("two_word last waddr", {96'd0, last_waddr}, 128'h4);
        check("model pin wdata", {96'd0, m_wdata}, 128'hAC08_0000);

        // Bad lengths, then bytes offered while not ready must be ignored.
        words = {};
        run_load("len0", 16'd0, 0, 1, 1'b0, 1'b0);
        run_load("len257", 16'd257, 0, 1, 1'b0, 1'b1);
        check("model pin error", {127'd0, m_error}, 128'd1);
        junk_bytes(4);

        // Backpressure: three idle cycles before every byte.
        words = '{32'h2008_0005, 32'hAC08_0000};
        run_load("backpressure", 16'd2, 3, 3, 1'b0, 1'b0);

        // Reset after two bytes of the first word.
        wr_count   = 0;
        start      = 1'b1;
        step();
        start      = 1'b0;
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h20, 0, 1'b0);
        send_byte(8'h08, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid-load reset outputs", {59'd0, byte_ready, we, busy, done, error, waddr, wdata}, 128'd0);
        check("mid-load reset writes", 128'(wr_count), 128'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        run_load("after_reset", 16'd2, 0, 2, 1'b0, 1'b0);
        check("after_reset mem[0] literal", {96'd0, dut_mem[0]}, 128'h2008_0005);

        // Full-size load with stray start pulses while busy.
        words = {};
        for (int i = 0; i < MEM; i++) words.push_back(32'(i));
        run_load("full", 16'(MEM), 0, 1, 1'b1, 1'b0);
        check("full last waddr", {96'd0, last_waddr}, 128'h3FC);
        check("full last wdata", {96'd0, last_wdata}, 128'hFF);

        // Restart from DONE with start and a byte offered together.
        words = '{32'hDEAD_BEEF};
        run_load("restart", 16'd1, 0, 0, 1'b0, 1'b1);
        check("restart mem[0] literal", {96'd0, dut_mem[0]}, 128'hDEAD_BEEF);
        check("restart waddr", {96'd0, last_waddr}, 128'h0);

        // Randomized loads, including out-of-range lengths.
        for (int t = 0; t < 12; t++) begin
            words = {};
            if ($urandom_range(4, 0) == 0) begin
                case ($urandom_range(2, 0))
                    0:       n = 16'd0;
                    1:       n = 16'hFFFF;
                    default: n = 16'(MEM + $urandom_range(300, 1));
                endcase
            end else begin
                n = 16'($urandom_range(7, 1));
                for (int i = 0; i < int'(n); i++) words.push_back($urandom);
            end
            run_load("random", n, 0, $urandom_range(3, 0), 1'($urandom), 1'($urandom));
            junk_bytes($urandom_range(3, 0));
        end

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
